// File: rtl/contactor_pkg.sv
// Shared types and constants for the ring contactor sequencer.
package contactor_pkg;

    localparam int unsigned NUM_CH_DEFAULT = 8;

    localparam int unsigned CH_A = 0;
    localparam int unsigned CH_B = 1;
    localparam int unsigned CH_C = 2;
    localparam int unsigned CH_D = 3;
    localparam int unsigned CH_E = 4;
    localparam int unsigned CH_F = 5;
    localparam int unsigned CH_G = 6;
    localparam int unsigned CH_H = 7;

    typedef enum logic [2:0] {
        ST_OPEN,
        ST_CLOSING,
        ST_CLOSED,
        ST_OPENING,
        ST_FAULT
    } ch_state_t;

endpackage

// File: rtl/contactor_channel.sv
// One contactor: feedback synchronizer and debouncer, coil FSM and supervision timer.
module contactor_channel
    import contactor_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_close,
    input  logic req_open,
    input  logic permit,
    input  logic fb,
    input  logic fault_clr,
    input  logic grant,
    output logic coil,
    output logic closed,
    output logic fault,
    output logic reject,
    output logic pending,
    output logic closing,
    output logic busy
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [1:0]    fb_sync;
    logic [DW-1:0] db_cnt;
    ch_state_t     state;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_inc;
    logic          timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_sync <= '0;
            db_cnt  <= '0;
            closed  <= 1'b0;
        end else begin
            fb_sync <= {fb_sync[0], fb};
            if (fb_sync[1] == closed) begin
                db_cnt <= '0;
            end else if (db_cnt == D_LAST) begin
                closed <= fb_sync[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    // Timer saturates at the limit; every state change below reloads it with zero.
    always_comb begin
        tcnt_inc  = (tcnt >= T_LIMIT) ? tcnt : tcnt + TW'(1);
        timed_out = (tcnt_inc >= T_LIMIT);
        closing   = (state == ST_CLOSING);
        busy      = (state == ST_CLOSING) || (state == ST_OPENING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_OPEN;
            tcnt    <= '0;
            pending <= 1'b0;
            coil    <= 1'b0;
            fault   <= 1'b0;
            reject  <= 1'b0;
        end else begin
            reject <= 1'b0;
            tcnt   <= tcnt_inc;
            case (state)
                ST_OPEN: begin
                    if (grant) begin
                        pending <= 1'b0;
                        if (permit) begin
                            state <= ST_CLOSING;
                            coil  <= 1'b1;
                            tcnt  <= '0;
                        end else begin
                            reject <= 1'b1;
                        end
                    end else if (req_open) begin
                        pending <= 1'b0;
                    end else if (req_close) begin
                        pending <= 1'b1;
                    end
                end
                ST_CLOSING: begin
                    if (closed) begin
                        state <= ST_CLOSED;
                        tcnt  <= '0;
                    end else if (timed_out) begin
                        state <= ST_FAULT;
                        coil  <= 1'b0;
                        fault <= 1'b1;
                        tcnt  <= '0;
                    end
                end
                ST_CLOSED: begin
                    // Lost feedback outranks a concurrent open or trip.
                    if (!closed) begin
                        state <= ST_FAULT;
                        coil  <= 1'b0;
                        fault <= 1'b1;
                        tcnt  <= '0;
                    end else if (req_open || !permit) begin
                        state <= ST_OPENING;
                        coil  <= 1'b0;
                        tcnt  <= '0;
                    end
                end
                ST_OPENING: begin
                    if (!closed) begin
                        state <= ST_OPEN;
                        tcnt  <= '0;
                    end else if (timed_out) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                        tcnt  <= '0;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr && !closed) begin
                        state <= ST_OPEN;
                        fault <= 1'b0;
                        tcnt  <= '0;
                    end
                end
                default: begin
                    state   <= ST_OPEN;
                    coil    <= 1'b0;
                    fault   <= 1'b0;
                    pending <= 1'b0;
                    tcnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/contactor_sequencer.sv
// Ring contactor sequencer: round-robin close arbiter with a single-CLOSING guard.
module contactor_sequencer
    import contactor_pkg::*;
#(
    parameter int unsigned NUM_CH          = NUM_CH_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_req_close,
    input  logic [NUM_CH-1:0] i_req_open,
    input  logic [NUM_CH-1:0] i_permit,
    input  logic [NUM_CH-1:0] i_fb,
    input  logic [NUM_CH-1:0] i_fault_clr,
    output logic [NUM_CH-1:0] o_coil,
    output logic [NUM_CH-1:0] o_closed,
    output logic [NUM_CH-1:0] o_fault,
    output logic [NUM_CH-1:0] o_reject,
    output logic              o_busy
);

    localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [1:0]        rst_sync;
    logic              rst_n_int;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] closing;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] grant;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     rr_next;
    logic [PW-1:0]     scan;

    // Assertion reaches every flop at once through rst_n_int; release takes two edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    always_comb begin
        grant   = '0;
        rr_next = rr_ptr;
        scan    = '0;
        if (closing == '0) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                scan = PW'((32'(rr_ptr) + k) % NUM_CH);
                if (grant == '0 && pending[scan]) begin
                    grant[scan] = 1'b1;
                    rr_next     = PW'((32'(scan) + 1) % NUM_CH);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) rr_ptr <= PW'(CH_A);
        else            rr_ptr <= rr_next;
    end

    assign o_busy = |busy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        contactor_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_ch (
            .clk      (i_clk),
            .rst_n    (rst_n_int),
            .req_close(i_req_close[i]),
            .req_open (i_req_open[i]),
            .permit   (i_permit[i]),
            .fb       (i_fb[i]),
            .fault_clr(i_fault_clr[i]),
            .grant    (grant[i]),
            .coil     (o_coil[i]),
            .closed   (o_closed[i]),
            .fault    (o_fault[i]),
            .reject   (o_reject[i]),
            .pending  (pending[i]),
            .closing  (closing[i]),
            .busy     (busy[i])
        );
    end

endmodule
